// File: rtl/matinv2_seq.sv
// matinv2_seq: sequential 2x2 fixed-point inverse, adj(A)/det(A), via restoring-division reciprocal.
// Optional MATINV2_ROUND_EN: round-half-up in the adjugate scaling multiplies.
module matinv2_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int BIN_POS     = 8,
  parameter int MATRIX_SIZE = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH*4-1:0] a,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH*4-1:0] inv,
  output logic                    singular
);
  localparam int W  = DATA_WIDTH;
  localparam int F  = BIN_POS;
  localparam int CW = $clog2(2 * W);
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W - 1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W - 1){1'b0}}};
  localparam logic [2*W-1:0] QMAX = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic [2*W-1:0] DVD0 = (2 * W)'(1) << (2 * F);
  localparam logic signed [2*W:0] HALF = (2 * W + 1)'(1) << (F - 1);
  localparam logic [CW-1:0] LAST = CW'(2 * W - 1);
`ifdef MATINV2_ROUND_EN
  localparam logic RND = 1'b1;
`else
  localparam logic RND = 1'b0;
`endif

  if (MATRIX_SIZE != 2 || BIN_POS >= DATA_WIDTH - 1 || BIN_POS < 1) begin : g_bad_cfg
    $error("matinv2_seq: unsupported configuration");
  end

  typedef enum logic [2:0] {IDLE, DET, RECIP, SCALE, DONE} state_t;

  function automatic logic signed [W-1:0] sat_w(input logic signed [2*W:0] v);
    return v > SMAX ? SMAX : v < SMIN ? SMIN : v[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] mulq(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                                               input logic rnd);
    logic signed [2*W:0] p;
    p = (2 * W + 1)'(x) * (2 * W + 1)'(y);
    if (rnd) p = p + HALF;
    return sat_w(p >>> F);
  endfunction

  function automatic logic signed [W-1:0] nsat(input logic signed [W-1:0] x);
    return x == SMIN ? SMAX : -x;
  endfunction

  state_t              state_q;
  logic                in_ready_q, out_valid_q, singular_q, neg_q;
  logic [4*W-1:0]      m_q, inv_q;
  logic [W-1:0]        div_q, rem_q;
  logic [2*W-1:0]      dvd_q, quo_q;
  logic [CW-1:0]       cnt_q;
  logic [1:0]          k_q;

  logic signed [W-1:0] ma, mb, mc, md, det_d, recip, adj, scl;
  logic signed [2*W:0] det_full;
  logic [W:0]          rem_sh;
  logic [W-1:0]        rem_d, qsat;
  logic                ge;

  assign ma       = m_q[0*W +: W];
  assign mb       = m_q[1*W +: W];
  assign mc       = m_q[2*W +: W];
  assign md       = m_q[3*W +: W];
  assign det_full = (2 * W + 1)'(mulq(ma, md, 1'b0)) - (2 * W + 1)'(mulq(mb, mc, 1'b0));
  assign det_d    = sat_w(det_full);
  assign rem_sh   = {rem_q, dvd_q[2*W-1]};
  assign ge       = rem_sh >= {1'b0, div_q};
  assign rem_d    = W'(ge ? rem_sh - {1'b0, div_q} : rem_sh);
  assign qsat     = quo_q > QMAX ? QMAX[W-1:0] : quo_q[W-1:0];
  assign recip    = neg_q ? -$signed(qsat) : $signed(qsat);
  assign adj      = k_q == 2'd0 ? md : k_q == 2'd1 ? nsat(mb) : k_q == 2'd2 ? nsat(mc) : ma;
  assign scl      = mulq(adj, recip, RND);

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign inv       = inv_q;
  assign singular  = singular_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      inv_q       <= '0;
      singular_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid && in_ready_q) begin
          m_q        <= a;
          in_ready_q <= 1'b0;
          state_q    <= DET;
        end
        DET: if (det_d == '0) begin
          inv_q      <= '0;
          singular_q <= 1'b1;
          state_q    <= DONE;
        end else begin
          singular_q <= 1'b0;
          div_q      <= det_d[W-1] ? -det_d : det_d;
          neg_q      <= det_d[W-1];
          rem_q      <= '0;
          quo_q      <= '0;
          dvd_q      <= DVD0;
          cnt_q      <= '0;
          state_q    <= RECIP;
        end
        RECIP: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[2*W-2:0], ge};
          dvd_q <= dvd_q << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            k_q     <= '0;
            state_q <= SCALE;
          end
        end
        SCALE: begin
          inv_q[k_q*W +: W] <= scl;
          k_q               <= k_q + 1'b1;
          if (k_q == 2'd3) state_q <= DONE;
        end
        DONE: if (!out_valid_q) out_valid_q <= 1'b1;
        else if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matinv2_seq.sv
// tb_matinv2_seq: table vectors, randomized matrices vs an integer-arithmetic model, backpressure and reset corners.
module tb_matinv2_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, singular;
  logic [63:0] a_v, inv_w;
  int          n_chk = 0, n_fail = 0;
`ifdef MATINV2_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  always #5 clk = ~clk;

  matinv2_seq #(.DATA_WIDTH(16), .BIN_POS(8), .MATRIX_SIZE(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a_v),
    .out_valid(out_valid), .out_ready(out_ready), .inv(inv_w), .singular(singular)
  );

  typedef struct {
    string       nm;
    logic [63:0] m;
    logic [63:0] e;
    logic        sing;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic longint clampw(input longint v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction

  function automatic longint mq(input longint x, input longint y, input bit rnd);
    longint p, q;
    p = x * y + (rnd ? 128 : 0);
    q = p / 256;
    if (p % 256 != 0 && p < 0) q = q - 1;
    return clampw(q);
  endfunction

  task automatic model(input logic [63:0] m, output logic [63:0] e, output logic s);
    longint x[4], adj[4], det, q, r;
    for (int i = 0; i < 4; i++) x[i] = longint'($signed(m[i*16 +: 16]));
    det = clampw(mq(x[0], x[3], 1'b0) - mq(x[1], x[2], 1'b0));
    e = '0;
    s = det == 0;
    if (!s) begin
      q = 65536 / (det < 0 ? -det : det);
      if (q > 32767) q = 32767;
      r = det < 0 ? -q : q;
      adj = '{x[3], clampw(-x[1]), clampw(-x[2]), x[0]};
      for (int k = 0; k < 4; k++) e[k*16 +: 16] = 16'(mq(adj[k], r, RND));
    end
  endtask

  task automatic run_mat(input logic [63:0] m, output logic [63:0] g_inv, output logic g_sing, output int g_lat);
    @(negedge clk);
    a_v      = m;
    in_valid = 1'b1;
    g_lat    = -1;
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        g_lat = i;
        break;
      end
    end
    g_inv  = inv_w;
    g_sing = singular;
  endtask

  task automatic handshake();
    @(negedge clk);
    chk("hs_busy_in_ready", 80'(in_ready), 80'(0));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("hs_after_ready_valid", 80'({in_ready, out_valid}), 80'(2'b10));
  endtask

  vec_t        tbl[5];
  logic [63:0] g_inv, e_inv, m, snap;
  logic        g_sing, e_sing;
  int          g_lat, ones;
  logic [15:0] ra, rb, rc, rd;

  initial begin
    tbl[0] = '{"identity", {16'h0100, 16'h0000, 16'h0000, 16'h0100}, {16'h0100, 16'h0000, 16'h0000, 16'h0100}, 1'b0, 38};
    tbl[1] = '{"diagonal", {16'h0400, 16'h0000, 16'h0000, 16'h0200}, {16'h0040, 16'h0000, 16'h0000, 16'h0080}, 1'b0, 38};
    tbl[2] = '{"neg_det",  {16'h0000, 16'h0100, 16'h0100, 16'h0000}, {16'h0000, 16'h0100, 16'h0100, 16'h0000}, 1'b0, 38};
    tbl[3] = '{"singular", {16'h0400, 16'h0200, 16'h0200, 16'h0100}, 64'h0, 1'b1, 2};
`ifdef MATINV2_ROUND_EN
    tbl[4] = '{"recip_sat", {16'h0010, 16'h0000, 16'h0000, 16'h0010}, {16'h0800, 16'h0000, 16'h0000, 16'h0800}, 1'b0, 38};
`else
    tbl[4] = '{"recip_sat", {16'h0010, 16'h0000, 16'h0000, 16'h0010}, {16'h07FF, 16'h0000, 16'h0000, 16'h07FF}, 1'b0, 38};
`endif
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_v = '0;
    repeat (3) @(posedge clk);
    #1 chk("reset_state", 80'({in_ready, out_valid, singular, inv_w}), 80'({1'b1, 1'b0, 1'b0, 64'h0}));
    @(negedge clk) rst = 1'b0;

    foreach (tbl[i]) begin
      run_mat(tbl[i].m, g_inv, g_sing, g_lat);
      chk({tbl[i].nm, "_inv"}, 80'(g_inv), 80'(tbl[i].e));
      chk({tbl[i].nm, "_singular"}, 80'(g_sing), 80'(tbl[i].sing));
      chk({tbl[i].nm, "_latency"}, 80'(g_lat), 80'(tbl[i].lat));
      handshake();
      chk({tbl[i].nm, "_inv_held"}, 80'(inv_w), 80'(tbl[i].e));
    end

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: begin ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom); rd = 16'($urandom); end
        1: begin
          ra = 16'($urandom_range(0, 2047)) - 16'd1024; rb = 16'($urandom_range(0, 2047)) - 16'd1024;
          rc = 16'($urandom_range(0, 2047)) - 16'd1024; rd = 16'($urandom_range(0, 2047)) - 16'd1024;
        end
        2: begin ra = 16'($urandom_range(0, 255)); rb = 16'h0; rc = 16'($urandom); rd = 16'h0; end
        default: begin
          ra = 16'h0100 + 16'($urandom_range(0, 63)); rb = 16'($urandom_range(0, 31));
          rc = 16'($urandom_range(0, 31)) - 16'd16; rd = 16'h0100 - 16'($urandom_range(0, 63));
        end
      endcase
      m = {rd, rc, rb, ra};
      model(m, e_inv, e_sing);
      run_mat(m, g_inv, g_sing, g_lat);
      chk("rand_inv", 80'(g_inv), 80'(e_inv));
      chk("rand_singular", 80'(g_sing), 80'(e_sing));
      chk("rand_latency", 80'(g_lat), 80'(e_sing ? 2 : 38));
      handshake();
    end

    run_mat(tbl[0].m, g_inv, g_sing, g_lat);
    snap = tbl[0].e;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = i[0];
      a_v      = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      @(posedge clk);
      #1 chk("bp_hold", 80'({in_ready, out_valid, singular, inv_w}), 80'({1'b0, 1'b1, 1'b0, snap}));
    end
    @(negedge clk) in_valid = 1'b0;
    handshake();
    ones = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1 ones += int'(out_valid);
    end
    chk("bp_pulses_ignored", 80'(ones), 80'(0));

    @(negedge clk);
    a_v = tbl[1].m;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk("rst_abort", 80'({in_ready, out_valid, singular, inv_w}), 80'({1'b1, 1'b0, 1'b0, 64'h0}));
    @(negedge clk) rst = 1'b0;
    ones = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1 ones += int'(out_valid);
    end
    chk("rst_no_stale", 80'(ones), 80'(0));
    run_mat(tbl[2].m, g_inv, g_sing, g_lat);
    chk("post_rst_inv", 80'({g_sing, g_inv}), 80'({1'b0, tbl[2].e}));
    chk("post_rst_latency", 80'(g_lat), 80'(38));
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
